fifo_read_controller: RTL and testbench

Read-domain control for the team's asynchronous FIFO. Sits directly downstream of the write-pointer Gray-code synchronizer: it consumes the already-synchronized, binary write pointer, fetches entries from a synchronous-read dual-port RAM, and presents them on a valid/ready stream. It exports its own binary read pointer, which the write domain synchronizes back through the same kind of Gray-code chain.

---
 rtl/fifo_read_controller_if.sv | 36 +++
 rtl/fifo_read_controller.sv | 92 +++++++++
 tb/tb_fifo_read_controller.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/fifo_read_controller_if.sv
// Signal bundle for fifo_read_controller: pointer exchange, RAM read port, output stream, status.
// pointer_error is present only when FIFO_READ_CONTROLLER_ERROR_CHECK_EN is defined.
interface fifo_read_controller_if #(
  parameter int ADDRESS_WIDTH = 4,
  parameter int DATA_WIDTH    = 8
);
  logic [ADDRESS_WIDTH:0]   write_pointer;
  logic                     read_enable;
  logic [ADDRESS_WIDTH-1:0] read_address;
  logic [DATA_WIDTH-1:0]    read_data;
  logic [ADDRESS_WIDTH:0]   read_pointer;
  logic [DATA_WIDTH-1:0]    out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic                     empty;
  logic [ADDRESS_WIDTH:0]   level;
`ifdef FIFO_READ_CONTROLLER_ERROR_CHECK_EN
  logic                     pointer_error;
`endif

  modport master (
    input  write_pointer, read_data, out_ready,
    output read_enable, read_address, read_pointer, out_data, out_valid, empty, level
`ifdef FIFO_READ_CONTROLLER_ERROR_CHECK_EN
    , output pointer_error
`endif
  );

  modport slave (
    output write_pointer, read_data, out_ready,
    input  read_enable, read_address, read_pointer, out_data, out_valid, empty, level
`ifdef FIFO_READ_CONTROLLER_ERROR_CHECK_EN
    , input pointer_error
`endif
  );
endinterface

// File: rtl/fifo_read_controller.sv
// Read-domain controller of the async FIFO: fetches from a sync-read RAM into a 2-slot output buffer.
// Optional sticky pointer_error output under FIFO_READ_CONTROLLER_ERROR_CHECK_EN.
module fifo_read_controller #(
  parameter int ADDRESS_WIDTH = 4,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  fifo_read_controller_if.master bus
);
  localparam int PW = ADDRESS_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH = {1'b1, {ADDRESS_WIDTH{1'b0}}};

  logic [PW-1:0]         read_pointer_q;
  logic [PW-1:0]         available;
  logic [PW-1:0]         level;
  logic [DATA_WIDTH-1:0] head_q;
  logic [DATA_WIDTH-1:0] second_q;
  logic [1:0]            count_q;
  logic                  in_flight_q;
  logic                  pop;
  logic                  fetch;
  logic [2:0]            occupancy;

  // Modulo subtraction absorbs pointer wrap.
  assign available = bus.write_pointer - read_pointer_q;
  assign pop       = (count_q != 2'd0) && bus.out_ready;
  // Slots committed after this cycle; pop requires count>0 so this never underflows.
  assign occupancy = {1'b0, count_q} + {2'b00, in_flight_q} - {2'b00, pop};
  assign fetch     = (available != '0) && (occupancy < 3'd2);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      read_pointer_q <= '0;
      in_flight_q    <= 1'b0;
    end else begin
      in_flight_q <= fetch;
      if (fetch) read_pointer_q <= read_pointer_q + PW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q   <= '0;
      second_q <= '0;
      count_q  <= 2'd0;
    end else begin
      case ({pop, in_flight_q})
        2'b11: begin
          if (count_q == 2'd1) begin
            head_q <= bus.read_data;
          end else begin
            head_q   <= second_q;
            second_q <= bus.read_data;
          end
        end
        2'b10: begin
          head_q  <= second_q;
          count_q <= count_q - 2'd1;
        end
        2'b01: begin
          if (count_q == 2'd0) head_q <= bus.read_data;
          else                 second_q <= bus.read_data;
          count_q <= count_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign level = available + {{(PW-2){1'b0}}, count_q} + {{(PW-1){1'b0}}, in_flight_q};

  assign bus.read_enable  = fetch;
  assign bus.read_address = read_pointer_q[ADDRESS_WIDTH-1:0];
  assign bus.read_pointer = read_pointer_q;
  assign bus.out_data     = head_q;
  assign bus.out_valid    = (count_q != 2'd0);
  assign bus.level        = level;
  assign bus.empty        = (level == '0);

`ifdef FIFO_READ_CONTROLLER_ERROR_CHECK_EN
  logic pointer_error_q;

  // More than DEPTH available can only come from a corrupted or backwards write pointer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                  pointer_error_q <= 1'b0;
    else if (available > DEPTH) pointer_error_q <= 1'b1;
  end

  assign bus.pointer_error = pointer_error_q;
`endif
endmodule

// File: tb/tb_fifo_read_controller.sv
// Bench for fifo_read_controller: directed scenarios plus random traffic against a queue-based model.
// Covers pointer_error when FIFO_READ_CONTROLLER_ERROR_CHECK_EN is defined.
module tb_fifo_read_controller;
  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic clock = 1'b0;
  logic reset;

  fifo_read_controller_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus();
  fifo_read_controller #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  logic [DW-1:0] mem [DEPTH];
  always @(posedge clock) if (bus.read_enable) bus.read_data <= mem[bus.read_address];

  int total = 0;
  int bad   = 0;

  // Model: unbounded integer pointers, a queue for the buffer, one in-flight entry.
  int          wp;
  int          m_rp;
  int          m_popped;
  int          m_if_valid;
  logic [7:0]  m_if_data;
  logic [7:0]  m_q[$];
  int          m_err;
  logic [7:0]  seen[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int wp_new, input int rdy);
    int avail, pop, fetch, lvl;
    wp = wp_new;
    bus.write_pointer = 5'(wp_new);
    bus.out_ready = (rdy != 0);
    #3;
    avail = wp - m_rp;
    pop   = (m_q.size() != 0 && rdy != 0) ? 1 : 0;
    fetch = (avail != 0 && (m_q.size() + m_if_valid - pop) < 2) ? 1 : 0;
    lvl   = avail + m_q.size() + m_if_valid;
    check_val("read_enable", 32'(bus.read_enable), 32'(fetch));
    check_val("read_address", 32'(bus.read_address), 32'(m_rp % DEPTH));
    check_val("read_pointer", 32'(bus.read_pointer), 32'(m_rp % (2*DEPTH)));
    check_val("out_valid", 32'(bus.out_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) check_val("out_data", 32'(bus.out_data), 32'(m_q[0]));
    check_val("level", 32'(bus.level), 32'(lvl));
    check_val("empty", 32'(bus.empty), 32'(lvl == 0));
`ifdef FIFO_READ_CONTROLLER_ERROR_CHECK_EN
    check_val("pointer_error", 32'(bus.pointer_error), 32'(m_err));
`endif
    if (bus.out_valid && rdy != 0) seen.push_back(bus.out_data);
    @(posedge clock);
    if (pop != 0) begin
      void'(m_q.pop_front());
      m_popped++;
    end
    if (m_if_valid != 0) m_q.push_back(m_if_data);
    m_if_valid = fetch;
    if (fetch != 0) begin
      m_if_data = mem[4'(m_rp % DEPTH)];
      m_rp++;
    end
    if (avail > DEPTH) m_err = 1;
    #1;
  endtask

  task automatic clear_model();
    wp = 0; m_rp = 0; m_popped = 0; m_if_valid = 0; m_err = 0;
    m_q.delete();
    seen.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.write_pointer = '0;
    bus.out_ready = 1'b0;
    clear_model();
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'(8'hA0 + i);
    reset = 1'b1;
    bus.write_pointer = '0;
    bus.out_ready = 1'b0;
    clear_model();
    #2;
    check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_val("rst_read_enable", 32'(bus.read_enable), 32'd0);
    check_val("rst_read_pointer", 32'(bus.read_pointer), 32'd0);
    check_val("rst_read_address", 32'(bus.read_address), 32'd0);
    check_val("rst_out_data", 32'(bus.out_data), 32'd0);
    check_val("rst_level", 32'(bus.level), 32'd0);
    check_val("rst_empty", 32'(bus.empty), 32'd1);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // latency: write_pointer 0->1 at cycle t
    step(0, 1);
    step(1, 1);
    check_val("lat_t1_valid", 32'(bus.out_valid), 32'd0);
    step(1, 1);
    check_val("lat_t2_valid", 32'(bus.out_valid), 32'd1);
    check_val("lat_t2_data", 32'(bus.out_data), 32'hA0);
    step(1, 1);
    check_val("lat_t3_empty", 32'(bus.empty), 32'd1);

    // full throughput from a full FIFO
    do_reset();
    for (int i = 0; i < 18; i++) step(16, 1);
    check_val("thru_pops", 32'(seen.size()), 32'd16);
    for (int i = 0; i < seen.size() && i < 16; i++) check_val("thru_data", 32'(seen[i]), 32'(160 + i));
    check_val("thru_read_pointer", 32'(bus.read_pointer), 32'd16);
    check_val("thru_empty", 32'(bus.empty), 32'd1);

    // backpressure
    do_reset();
    for (int i = 0; i < 6; i++) step(5, 0);
    check_val("bp_read_pointer", 32'(bus.read_pointer), 32'd2);
    check_val("bp_level", 32'(bus.level), 32'd5);
    check_val("bp_out_data", 32'(bus.out_data), 32'hA0);
    for (int i = 0; i < 7; i++) step(5, 1);
    check_val("bp_pops", 32'(seen.size()), 32'd5);
    for (int i = 0; i < seen.size() && i < 5; i++) check_val("bp_data", 32'(seen[i]), 32'(160 + i));

    // wrap: bring both pointers to 30, then write_pointer 30 -> 2
    do_reset();
    for (int i = 0; i < 36; i++) step((i < 30) ? i : 30, 1);
    check_val("wrap_pre_rp", 32'(bus.read_pointer), 32'd30);
    seen.delete();
    for (int i = 0; i < 8; i++) step(34, 1);
    check_val("wrap_pops", 32'(seen.size()), 32'd4);
    if (seen.size() == 4) begin
      check_val("wrap_d0", 32'(seen[0]), 32'hAE);
      check_val("wrap_d1", 32'(seen[1]), 32'hAF);
      check_val("wrap_d2", 32'(seen[2]), 32'hA0);
      check_val("wrap_d3", 32'(seen[3]), 32'hA1);
    end
    check_val("wrap_read_pointer", 32'(bus.read_pointer), 32'd2);

    // reset mid-stream, write domain reset alongside
    do_reset();
    for (int i = 1; i < 7; i++) step(i, 1);
    reset = 1'b1;
    bus.write_pointer = '0;
    #1;
    check_val("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_val("mid_rst_level", 32'(bus.level), 32'd0);
    check_val("mid_rst_read_pointer", 32'(bus.read_pointer), 32'd0);
    check_val("mid_rst_empty", 32'(bus.empty), 32'd1);
    do_reset();

`ifdef FIFO_READ_CONTROLLER_ERROR_CHECK_EN
    do_reset();
    step(17, 0);
    check_val("err_set", 32'(bus.pointer_error), 32'd1);
    for (int i = 0; i < 4; i++) step(17, 0);
    check_val("err_sticky", 32'(bus.pointer_error), 32'd1);
    do_reset();
    check_val("err_cleared", 32'(bus.pointer_error), 32'd0);
`endif

    // random traffic with random RAM contents; last 40 cycles drain
    do_reset();
    for (int c = 0; c < 400; c++) begin
      int n, room, rdy;
      n    = $urandom_range(0, 3);
      room = DEPTH - (wp - m_popped);
      if (c >= 360) n = 0;
      if (n > room) n = room;
      for (int k = 0; k < n; k++) mem[4'((wp + k) % DEPTH)] = 8'($urandom);
      rdy = (c >= 360) ? 1 : (($urandom_range(0, 3) != 0) ? 1 : 0);
      step(wp + n, rdy);
    end
    check_val("rand_drained", 32'(bus.empty), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
